// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches ps2c, deframes 11-bit frames and
// reports make codes (E0 prefixes dropped, F0 break sequences suppressed).
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keycode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] key_code,
  output logic       code_valid,
  output logic       parity_err
);

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  localparam logic [16:0] TmoLimit = 17'(TIMEOUT_CYCLES);
  localparam logic [7:0]  CodeExt  = 8'hE0;
  localparam logic [7:0]  CodeBrk  = 8'hF0;

  // Input synchronisers
  logic [1:0] ps2c_sync_q;
  logic [1:0] ps2d_sync_q;
  logic       ps2c_s;
  logic       ps2d_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], ps2c};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2d};
    end
  end

  assign ps2c_s = ps2c_sync_q[1];
  assign ps2d_s = ps2d_sync_q[1];

  // Clock deglitch filter: level only moves once the whole window agrees
  logic [FILTER_LEN-1:0] filt_q;
  logic                  level_q;
  logic                  level_d;
  logic                  level_prev_q;
  logic                  fall;

  always_comb begin
    level_d = level_q;
    if (&filt_q) begin
      level_d = 1'b1;
    end else if (~|filt_q) begin
      level_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q       <= '1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
    end else begin
      filt_q       <= {filt_q[FILTER_LEN-2:0], ps2c_s};
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign fall = level_prev_q & ~level_q;

  // Frame receiver
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic [16:0] tmo_q, tmo_d;
  logic [16:0] tmo_inc;
  logic        break_q, break_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        code_valid_q, code_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[8:0];
`else
  assign parity_ok = 1'b1;
`endif

  assign tmo_inc = tmo_q + 17'd1;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = 17'd0;
    break_d      = break_q;
    key_code_d   = key_code_q;
    code_valid_d = 1'b0;
    parity_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall && rx_en && !ps2d_s) begin
          bit_cnt_d = 4'd9;
          state_d   = StShift;
        end
      end

      StShift: begin
        if (fall) begin
          shift_d = {ps2d_s, shift_q[9:1]};
          if (bit_cnt_q == 4'd0) begin
            state_d = StLoad;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end else if (tmo_inc == TmoLimit) begin
          // Keyboard stalled mid-frame: resynchronise and forget any pending break
          state_d = StIdle;
          break_d = 1'b0;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      StLoad: begin
        state_d = StIdle;
        // shift_q = {stop, parity, data[7:0]}
        if (shift_q[9]) begin
          if (!parity_ok) begin
            parity_err_d = 1'b1;
          end else if (shift_q[7:0] == CodeExt) begin
            break_d = break_q;
          end else if (shift_q[7:0] == CodeBrk) begin
            break_d = 1'b1;
          end else if (break_q) begin
            break_d = 1'b0;
          end else begin
            key_code_d   = shift_q[7:0];
            code_valid_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '1;
      tmo_q        <= 17'd0;
      break_q      <= 1'b0;
      key_code_q   <= 8'h00;
      code_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      break_q      <= break_d;
      key_code_q   <= key_code_d;
      code_valid_q <= code_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign key_code   = key_code_q;
  assign code_valid = code_valid_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: frame-level reference model plus directed and
// randomised PS/2 traffic with glitches, rx_en changes, timeouts and mid-frame reset.
module tb_ps2_keycode_rx;

  localparam int unsigned Filt = 8;
  localparam int unsigned Tmo  = 200;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] key_code;
  logic       code_valid;
  logic       parity_err;

  ps2_keycode_rx #(
    .FILTER_LEN    (Filt),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .key_code  (key_code),
    .code_valid(code_valid),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected strobes in order (0..255 = make code, 256 = parity error)
  int         exp_q[$];
  logic [7:0] model_code  = 8'h00;
  bit         model_break = 1'b0;
  int         n_code = 0;
  int         n_perr = 0;
  int         last_strobe_cyc = 0;
  int         got_v;
  int         want_v;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (code_valid || parity_err) begin
        got_v  = (code_valid && parity_err) ? 512 : (code_valid ? int'(key_code) : 256);
        want_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("strobe", got_v, want_v);
        if (code_valid) begin
          n_code++;
          last_strobe_cyc = cyc;
          if (want_v >= 0 && want_v < 256) model_code = want_v[7:0];
        end
        if (parity_err) n_perr++;
      end
      check("key_code", int'(key_code), int'(model_code));
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit par_bad,
                                           input bit stop_bad);
    return {~stop_bad, (~^d) ^ par_bad, d, 1'b0};
  endfunction

  task automatic model_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
    if (stop_bad) return;
`ifdef PS2_PARITY_CHECK_EN
    if (par_bad) begin
      exp_q.push_back(256);
      return;
    end
`endif
    if (d == 8'hE0) return;
    if (d == 8'hF0) begin
      model_break = 1'b1;
      return;
    end
    if (model_break) begin
      model_break = 1'b0;
      return;
    end
    exp_q.push_back(int'(d));
  endtask

  // Drives nbits of a frame; optional 1-clk glitches inside each phase.
  task automatic send_bits(input logic [10:0] fr, input int nbits, input bit drop_rx,
                           output int last_fall);
    last_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      int h;
      bit gh;
      bit gl;
      h  = int'($urandom_range(20, 14));
      gh = ($urandom_range(9, 0) < 3);
      gl = ($urandom_range(9, 0) < 3);
      wait_clks(4);
      ps2d = fr[i];
      if (drop_rx && i == 3) rx_en = 1'b0;
      if (gh) begin
        wait_clks(10);
        ps2c = 1'b0;
        wait_clks(1);
        ps2c = 1'b1;
        wait_clks(h);
      end else begin
        wait_clks(h - 4);
      end
      ps2c = 1'b0;
      if (i == nbits - 1) last_fall = cyc;
      if (gl) begin
        wait_clks(14);
        ps2c = 1'b1;
        wait_clks(1);
        ps2c = 1'b0;
      end
      wait_clks(h);
      ps2c = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad,
                            input bit en, input bit drop_rx, output int last_fall);
    rx_en = en;
    wait_clks(20);
    if (en) model_frame(d, par_bad, stop_bad);
    send_bits(mk_frame(d, par_bad, stop_bad), 11, drop_rx, last_fall);
    ps2d = 1'b1;
    wait_clks(40);
    check("pending_strobes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_ok(input logic [7:0] d);
    int lf;
    send_frame(d, 1'b0, 1'b0, 1'b1, 1'b0, lf);
  endtask

  initial begin
    int lf;
    int c0;
    int p0;
    int dl;
    reset_n = 1'b0;
    ps2c    = 1'b1;
    ps2d    = 1'b1;
    rx_en   = 1'b0;
    wait_clks(5);
    check("reset_key_code", int'(key_code), 0);
    check("reset_code_valid", int'(code_valid), 0);
    check("reset_parity_err", int'(parity_err), 0);
    reset_n = 1'b1;
    wait_clks(5);

    // Single make code and its latency from the stop-bit edge
    c0 = n_code;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, lf);
    check("first_key", int'(key_code), 'h1C);
    check("first_count", n_code - c0, 1);
    dl = last_strobe_cyc - lf;
    n_checks++;
    if (dl < int'(Filt) + 3 || dl > int'(Filt) + 8) begin
      n_fail++;
      $display("FAIL latency: actual=%0d clks required=%0d..%0d", dl, Filt + 3, Filt + 8);
    end

    // Break sequence suppresses the release
    c0 = n_code;
    send_ok(8'h1C);
    send_ok(8'hF0);
    send_ok(8'h1C);
    check("break_count", n_code - c0, 1);
    check("break_key", int'(key_code), 'h1C);

    // Extended prefix dropped, extended release suppressed
    c0 = n_code;
    send_ok(8'hE0);
    send_ok(8'h75);
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h75);
    check("ext_count", n_code - c0, 1);
    check("ext_key", int'(key_code), 'h75);

    // Flipped parity
    c0 = n_code;
    p0 = n_perr;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, lf);
`ifdef PS2_PARITY_CHECK_EN
    check("par_perr_count", n_perr - p0, 1);
    check("par_code_count", n_code - c0, 0);
    check("par_key", int'(key_code), 'h75);
`else
    check("par_perr_count", n_perr - p0, 0);
    check("par_code_count", n_code - c0, 1);
    check("par_key", int'(key_code), 'h5A);
`endif

    // Stalled partial frame times out and clears a pending break
    c0 = n_code;
    send_ok(8'hF0);
    rx_en = 1'b1;
    wait_clks(20);
    send_bits(mk_frame(8'h99, 1'b0, 1'b0), 5, 1'b0, lf);
    wait_clks(Tmo + 50);
    model_break = 1'b0;
    send_ok(8'h23);
    check("tmo_count", n_code - c0, 1);
    check("tmo_key", int'(key_code), 'h23);

    // Idle glitches with data low must not start a frame
    ps2d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_clks(int'($urandom_range(12, 3)));
      ps2c = 1'b0;
      wait_clks(1);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    send_ok(8'h34);
    check("glitch_key", int'(key_code), 'h34);

    // Reset in the middle of bit 4, with a break pending
    send_ok(8'hF0);
    rx_en = 1'b1;
    wait_clks(20);
    send_bits(mk_frame(8'h66, 1'b0, 1'b0), 4, 1'b0, lf);
    wait_clks(4);
    ps2d = 1'b1;
    wait_clks(10);
    ps2c = 1'b0;
    wait_clks(5);
    reset_n = 1'b0;
    model_code  = 8'h00;
    model_break = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_key", int'(key_code), 0);
    check("midreset_valid", int'(code_valid), 0);
    check("midreset_perr", int'(parity_err), 0);
    ps2c = 1'b1;
    wait_clks(10);
    reset_n = 1'b1;
    wait_clks(10);
    c0 = n_code;
    send_ok(8'h2B);
    check("postreset_count", n_code - c0, 1);
    check("postreset_key", int'(key_code), 'h2B);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [7:0] d;
      r = int'($urandom_range(99, 0));
      d = (r < 10) ? 8'hE0 : (r < 22) ? 8'hF0 : 8'($urandom_range(255, 0));
      send_frame(d, ($urandom_range(99, 0) < 10), ($urandom_range(99, 0) < 8),
                 ($urandom_range(99, 0) < 90), ($urandom_range(99, 0) < 10), lf);
    end

    wait_clks(20);
    check("final_key", int'(key_code), int'(model_code));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
